bpu_tournament: RTL

//  Tournament branch predictor in IF. Combines a local (PC-indexed) table, a global (gshare) table
//  and a chooser, fronted by a direct-mapped BTB. Gives fetch a same-cycle direction, target and tag.

---
 rtl/bpu_tournament_pkg.sv | 32 +++
 rtl/bpu_tournament_btb.sv | 51 +++++
 rtl/bpu_tournament.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bpu_tournament_pkg.sv
// Shared definitions for the tournament branch predictor: default widths,
// jump-type codes, counter reset value and the 2-bit saturating counter step.
package bpu_tournament_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int HISLEN_DEF      = 8;
  localparam int LOCAL_IDX_W_DEF = 8;
  localparam int BTB_IDX_W_DEF   = 4;

  typedef enum logic [1:0] {
    JT_NONE   = 2'b00,
    JT_JAL    = 2'b01,
    JT_JALR   = 2'b10,
    JT_BRANCH = 2'b11
  } jump_type_e;

  // Weak not-taken for PHTs, weak local for the chooser.
  localparam logic [1:0] SATCNT_INIT = 2'b01;

  // One step of a 2-bit saturating counter: up when inc=1, down otherwise.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic inc);
    logic [1:0] nxt;
    nxt = cnt;
    if (inc) begin
      if (cnt != 2'b11) nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_tournament_btb.sv
// bpu_btb: direct-mapped branch target buffer, asynchronous read, synchronous
// write. Only the valid bits are reset; tag/target/type are qualified by valid.
module bpu_btb #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [XLEN-1:0]  rd_tag,
  output logic [XLEN-1:0]  rd_target,
  output logic [1:0]       rd_type,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]  wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [1:0]       wr_type
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid;
  logic [XLEN-1:0]  tag_mem    [DEPTH];
  logic [XLEN-1:0]  target_mem [DEPTH];
  logic [1:0]       type_mem   [DEPTH];

  // Valid bits: cleared by reset, set on allocation; reset wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Entry payload: overwritten on every allocation (alias or new target).
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
      type_mem[wr_idx]   <= wr_type;
    end
  end

  assign rd_valid  = valid[rd_idx];
  assign rd_tag    = tag_mem[rd_idx];
  assign rd_target = target_mem[rd_idx];
  assign rd_type   = type_mem[rd_idx];

endmodule

// File: rtl/bpu_tournament.sv
// bpu_tournament: local + gshare tournament predictor with a chooser and a
// direct-mapped BTB. Lookup is combinational; training happens at posedge
// from commit-time feedback. Optional macro BPU_PERF_CNT_EN adds
// branch/mispredict counters.
//
// Update interface: upd_valid_i is a single-cycle strobe with no ready side;
// the predictor always accepts, and the upd_* fields are only meaningful in
// the cycle upd_valid_i is high. A lookup in that same cycle sees the state
// from before the update (no bypass).
module bpu_tournament
  import bpu_tournament_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int HISLEN      = HISLEN_DEF,
  parameter int LOCAL_IDX_W = LOCAL_IDX_W_DEF,
  parameter int BTB_IDX_W   = BTB_IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              pdt_res_o,
  output logic              which_pdt_o,
  output logic [HISLEN-1:0] history_o,
  output logic [XLEN-1:0]   pdt_tag_o,
  output logic [XLEN-1:0]   pdt_target_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic [1:0]        upd_type_i,
  input  logic              upd_taken_i,
  input  logic              upd_correct_i,
  input  logic              upd_which_pdt_i,
  input  logic [HISLEN-1:0] upd_history_i,
  input  logic [XLEN-1:0]   upd_target_i
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branch_cnt_o,
  output logic [31:0]       perf_miss_cnt_o
`endif
);

  localparam int LPHT_DEPTH = 1 << LOCAL_IDX_W;
  localparam int GPHT_DEPTH = 1 << HISLEN;

  logic [1:0]        lpht    [LPHT_DEPTH];
  logic [1:0]        gpht    [GPHT_DEPTH];
  logic [1:0]        chooser [GPHT_DEPTH];
  logic [HISLEN-1:0] ghr;

  // Lookup indices (bit 0 dropped so compressed instructions spread out).
  logic [LOCAL_IDX_W-1:0] lidx;
  logic [HISLEN-1:0]      gidx, cidx;
  logic [BTB_IDX_W-1:0]   bidx;

  // Update indices.
  logic [LOCAL_IDX_W-1:0] upd_lidx;
  logic [HISLEN-1:0]      upd_gidx, upd_cidx;
  logic [BTB_IDX_W-1:0]   upd_bidx;

  logic            upd_en, upd_branch, chooser_inc, btb_wr;
  logic            btb_v, hit, dir;
  logic [XLEN-1:0] btb_tag, btb_target;
  logic [1:0]      btb_type;

  assign lidx = if_pc_i[LOCAL_IDX_W:1];
  assign cidx = if_pc_i[HISLEN:1];
  assign gidx = if_pc_i[HISLEN:1] ^ ghr;
  assign bidx = if_pc_i[BTB_IDX_W:1];

  assign upd_lidx = upd_pc_i[LOCAL_IDX_W:1];
  assign upd_cidx = upd_pc_i[HISLEN:1];
  assign upd_gidx = upd_pc_i[HISLEN:1] ^ upd_history_i;
  assign upd_bidx = upd_pc_i[BTB_IDX_W:1];

  assign upd_en      = upd_valid_i && (upd_type_i != JT_NONE);
  assign upd_branch  = upd_en && (upd_type_i == JT_BRANCH);
  // Correct: reinforce the predictor that was used; wrong: lean to the other.
  assign chooser_inc = upd_correct_i ? upd_which_pdt_i : ~upd_which_pdt_i;
  assign btb_wr      = upd_en && upd_taken_i && !rst;

  bpu_btb #(
    .XLEN  (XLEN),
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bidx),
    .rd_valid  (btb_v),
    .rd_tag    (btb_tag),
    .rd_target (btb_target),
    .rd_type   (btb_type),
    .wr_en     (btb_wr),
    .wr_idx    (upd_bidx),
    .wr_tag    (upd_pc_i),
    .wr_target (upd_target_i),
    .wr_type   (upd_type_i)
  );

  // Combinational prediction: jumps on a hit are always taken; branches
  // follow whichever table the chooser currently favours.
  always_comb begin
    hit          = btb_v && (btb_tag == if_pc_i);
    dir          = chooser[cidx][1] ? gpht[gidx][1] : lpht[lidx][1];
    pdt_res_o    = hit && ((btb_type != JT_BRANCH) || dir);
    which_pdt_o  = chooser[cidx][1];
    history_o    = ghr;
    pdt_tag_o    = hit ? btb_tag : '0;
    pdt_target_o = hit ? btb_target : '0;
  end

  // Direction tables and GHR: trained by resolved conditional branches only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LPHT_DEPTH; i++) lpht[i] <= SATCNT_INIT;
      for (int i = 0; i < GPHT_DEPTH; i++) begin
        gpht[i]    <= SATCNT_INIT;
        chooser[i] <= SATCNT_INIT;
      end
      ghr <= '0;
    end else if (upd_branch) begin
      lpht[upd_lidx]    <= sat_update(lpht[upd_lidx], upd_taken_i);
      gpht[upd_gidx]    <= sat_update(gpht[upd_gidx], upd_taken_i);
      chooser[upd_cidx] <= sat_update(chooser[upd_cidx], chooser_inc);
      ghr               <= {ghr[HISLEN-2:0], upd_taken_i};
    end
  end

`ifdef BPU_PERF_CNT_EN
  // Performance counters: every real update, and those that were mispredicted.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branch_cnt_o <= '0;
      perf_miss_cnt_o   <= '0;
    end else if (upd_en) begin
      perf_branch_cnt_o <= perf_branch_cnt_o + 32'd1;
      if (!upd_correct_i) perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
